// File: rtl/csi_packet_parser.sv
// csi_packet_parser
// Decodes CSI-2 packet headers from the header finder's 32-bit word stream,
// classifies packets as short or long, strips long-packet payload into
// byte-enabled words and captures the 16-bit packet footer (CRC).
//
// Ports:
//   rxbyteclkhs   byte clock, all logic on its rising edge
//   reset         synchronous active-high reset
//   in_data       input word, byte0 = [7:0] earliest on the wire
//   in_valid      in_data valid this cycle
//   in_ph         in_data is a packet header (qualified by in_valid)
//   vc, dt, word_count, ecc   header fields, held until the next header
//   hdr_valid     pulse when a header is decoded
//   frame_start, frame_end, line_start, line_end   short-packet sync pulses
//   payload_data, payload_be, payload_valid, payload_last   payload stream
//   crc, crc_valid   packet footer {high, low} and its capture pulse
//   pkt_abort     pulse when a header interrupts an unfinished long packet
module csi_packet_parser #(
  parameter logic [5:0] LONG_DT_MIN = 6'h10,
  parameter int         CNT_W       = 17
) (
  input  logic        rxbyteclkhs,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_ph,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] word_count,
  output logic [7:0]  ecc,
  output logic        hdr_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [31:0] payload_data,
  output logic [3:0]  payload_be,
  output logic        payload_valid,
  output logic        payload_last,
  output logic [15:0] crc,
  output logic        crc_valid,
  output logic        pkt_abort
);

  typedef enum logic [1:0] {IDLE, BODY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [7:0]         crc_lo_q, crc_lo_d;
  logic [1:0]         vc_q, vc_d;
  logic [5:0]         dt_q, dt_d;
  logic [15:0]        wc_q, wc_d;
  logic [7:0]         ecc_q, ecc_d;
  logic               hdr_valid_q, hdr_valid_d;
  logic               fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic [31:0]        pdata_q, pdata_d;
  logic [3:0]         pbe_q, pbe_d;
  logic               pvalid_q, pvalid_d;
  logic               plast_q, plast_d;
  logic [15:0]        crc_q, crc_d;
  logic               crc_valid_q, crc_valid_d;
  logic               abort_q, abort_d;

  logic signed [CNT_W:0] lane_rem;
  logic [7:0]            lane_byte;

  // Next-state logic. rem counts the body bytes still expected, including
  // the two CRC bytes, measured from lane 0 of the current word. Lanes are
  // walked low to high so a CRC low byte captured in this word is already
  // visible in crc_lo_d when the high byte follows in a higher lane.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    crc_lo_d    = crc_lo_q;
    vc_d        = vc_q;
    dt_d        = dt_q;
    wc_d        = wc_q;
    ecc_d       = ecc_q;
    crc_d       = crc_q;
    hdr_valid_d = 1'b0;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ls_d        = 1'b0;
    le_d        = 1'b0;
    pdata_d     = 32'h0;
    pbe_d       = 4'h0;
    pvalid_d    = 1'b0;
    plast_d     = 1'b0;
    crc_valid_d = 1'b0;
    abort_d     = 1'b0;
    lane_rem    = '0;
    lane_byte   = 8'h0;

    if (in_valid && in_ph) begin
      vc_d        = in_data[7:6];
      dt_d        = in_data[5:0];
      wc_d        = in_data[23:8];
      ecc_d       = in_data[31:24];
      hdr_valid_d = 1'b1;
      abort_d     = (state_q == BODY);
      if (in_data[5:0] < LONG_DT_MIN) begin
        case (in_data[5:0])
          6'h00:   fs_d = 1'b1;
          6'h01:   fe_d = 1'b1;
          6'h02:   ls_d = 1'b1;
          6'h03:   le_d = 1'b1;
          default: ;
        endcase
        state_d = DONE;
      end else begin
        rem_d   = CNT_W'(in_data[23:8]) + CNT_W'(2);
        state_d = BODY;
      end
    end else if (in_valid && (state_q == BODY)) begin
      for (int i = 0; i < 4; i++) begin
        lane_rem  = $signed({1'b0, rem_q}) - $signed((CNT_W+1)'(i));
        lane_byte = in_data[8*i +: 8];
        if (lane_rem > 2) begin
          pbe_d[i]          = 1'b1;
          pdata_d[8*i +: 8] = lane_byte;
        end else if (lane_rem == 2) begin
          crc_lo_d = lane_byte;
        end else if (lane_rem == 1) begin
          crc_d       = {lane_byte, crc_lo_d};
          crc_valid_d = 1'b1;
        end
      end
      pvalid_d = |pbe_d;
      // The final payload byte sits in this word exactly when 3..6 bytes remain.
      plast_d  = (rem_q >= CNT_W'(3)) && (rem_q <= CNT_W'(6));
      rem_d    = (rem_q > CNT_W'(4)) ? rem_q - CNT_W'(4) : '0;
      state_d  = (rem_q <= CNT_W'(4)) ? DONE : BODY;
    end
  end

  // All state and outputs registered in one place.
  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      crc_lo_q    <= 8'h0;
      vc_q        <= 2'h0;
      dt_q        <= 6'h0;
      wc_q        <= 16'h0;
      ecc_q       <= 8'h0;
      hdr_valid_q <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      pdata_q     <= 32'h0;
      pbe_q       <= 4'h0;
      pvalid_q    <= 1'b0;
      plast_q     <= 1'b0;
      crc_q       <= 16'h0;
      crc_valid_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      crc_lo_q    <= crc_lo_d;
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      wc_q        <= wc_d;
      ecc_q       <= ecc_d;
      hdr_valid_q <= hdr_valid_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      pdata_q     <= pdata_d;
      pbe_q       <= pbe_d;
      pvalid_q    <= pvalid_d;
      plast_q     <= plast_d;
      crc_q       <= crc_d;
      crc_valid_q <= crc_valid_d;
      abort_q     <= abort_d;
    end
  end

  assign vc            = vc_q;
  assign dt            = dt_q;
  assign word_count    = wc_q;
  assign ecc           = ecc_q;
  assign hdr_valid     = hdr_valid_q;
  assign frame_start   = fs_q;
  assign frame_end     = fe_q;
  assign line_start    = ls_q;
  assign line_end      = le_q;
  assign payload_data  = pdata_q;
  assign payload_be    = pbe_q;
  assign payload_valid = pvalid_q;
  assign payload_last  = plast_q;
  assign crc           = crc_q;
  assign crc_valid     = crc_valid_q;
  assign pkt_abort     = abort_q;

endmodule

// File: tb/tb_csi_packet_parser.sv
// tb_csi_packet_parser
// Drives csi_packet_parser with directed and randomized word streams and
// compares every output after every clock against a byte-position model:
// each long packet body is treated as a flat byte sequence where byte
// index < WC is payload, WC is CRC low, WC+1 is CRC high, beyond is filler.
module tb_csi_packet_parser;

  logic        rxbyteclkhs = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ph;
  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic        hdr_valid, frame_start, frame_end, line_start, line_end;
  logic [31:0] payload_data;
  logic [3:0]  payload_be;
  logic        payload_valid, payload_last;
  logic [15:0] crc;
  logic        crc_valid, pkt_abort;

  int checks = 0;
  int errors = 0;

  csi_packet_parser dut (
    .rxbyteclkhs   (rxbyteclkhs),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ph         (in_ph),
    .vc            (vc),
    .dt            (dt),
    .word_count    (word_count),
    .ecc           (ecc),
    .hdr_valid     (hdr_valid),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .line_start    (line_start),
    .line_end      (line_end),
    .payload_data  (payload_data),
    .payload_be    (payload_be),
    .payload_valid (payload_valid),
    .payload_last  (payload_last),
    .crc           (crc),
    .crc_valid     (crc_valid),
    .pkt_abort     (pkt_abort)
  );

  always #5 rxbyteclkhs = ~rxbyteclkhs;

  // Reference model state and expected outputs.
  bit          mInLong;
  int          mPos;
  int          mWc;
  logic [7:0]  mCrcLo;
  logic [1:0]  eVc;
  logic [5:0]  eDt;
  logic [15:0] eWc;
  logic [7:0]  eEcc;
  logic        eHdr, eFs, eFe, eLs, eLe;
  logic [31:0] ePdata;
  logic [3:0]  eBe;
  logic        ePv, eLast;
  logic [15:0] eCrc;
  logic        eCrcV, eAbort;

  // Model of one clock: what the outputs must show after this edge.
  task automatic modelStep(input logic rst, input logic v, input logic ph, input logic [31:0] d);
    int p;
    eHdr = 0; eFs = 0; eFe = 0; eLs = 0; eLe = 0;
    ePdata = 0; eBe = 0; ePv = 0; eLast = 0; eCrcV = 0; eAbort = 0;
    if (rst) begin
      mInLong = 0; mPos = 0; mWc = 0; mCrcLo = 0;
      eVc = 0; eDt = 0; eWc = 0; eEcc = 0; eCrc = 0;
    end else if (v && ph) begin
      eAbort = mInLong;
      eVc = d[7:6]; eDt = d[5:0]; eWc = d[23:8]; eEcc = d[31:24];
      eHdr = 1;
      if (d[5:0] < 6'h10) begin
        eFs = (d[5:0] == 6'h00);
        eFe = (d[5:0] == 6'h01);
        eLs = (d[5:0] == 6'h02);
        eLe = (d[5:0] == 6'h03);
        mInLong = 0;
      end else begin
        mInLong = 1;
        mPos = 0;
        mWc = int'(d[23:8]);
      end
    end else if (v && mInLong) begin
      for (int lane = 0; lane < 4; lane++) begin
        p = mPos + lane;
        if (p < mWc) begin
          eBe[lane] = 1;
          ePdata[8*lane +: 8] = d[8*lane +: 8];
          if (p == mWc - 1) eLast = 1;
        end else if (p == mWc) begin
          mCrcLo = d[8*lane +: 8];
        end else if (p == mWc + 1) begin
          eCrc = {d[8*lane +: 8], mCrcLo};
          eCrcV = 1;
        end
      end
      ePv = |eBe;
      mPos += 4;
      if (mPos >= mWc + 2) mInLong = 0;
    end
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkField("vc", 32'(vc), 32'(eVc));
    checkField("dt", 32'(dt), 32'(eDt));
    checkField("word_count", 32'(word_count), 32'(eWc));
    checkField("ecc", 32'(ecc), 32'(eEcc));
    checkField("hdr_valid", 32'(hdr_valid), 32'(eHdr));
    checkField("sync", 32'({frame_start, frame_end, line_start, line_end}),
               32'({eFs, eFe, eLs, eLe}));
    checkField("payload_data", payload_data, ePdata);
    checkField("payload_be", 32'(payload_be), 32'(eBe));
    checkField("payload_valid", 32'(payload_valid), 32'(ePv));
    checkField("payload_last", 32'(payload_last), 32'(eLast));
    checkField("crc", 32'(crc), 32'(eCrc));
    checkField("crc_valid", 32'(crc_valid), 32'(eCrcV));
    checkField("pkt_abort", 32'(pkt_abort), 32'(eAbort));
  endtask

  // Drive one cycle of input, advance model and DUT, then compare.
  task automatic applyStimulus(input logic rst, input logic v, input logic ph, input logic [31:0] d);
    reset = rst; in_valid = v; in_ph = ph; in_data = d;
    modelStep(rst, v, ph, d);
    @(posedge rxbyteclkhs);
    #1;
    checkOutput();
  endtask

  function automatic logic [31:0] hdrWord(input logic [7:0] e, input logic [15:0] wc,
                                          input logic [1:0] v, input logic [5:0] t);
    return {e, wc[15:8], wc[7:0], v, t};
  endfunction

  initial begin
    int wc, nWords, sent;
    logic [5:0] rdt;
    logic [31:0] w;

    reset = 1; in_valid = 0; in_ph = 0; in_data = 0;
    #1;
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 1, 1, 32'h1A000540);
    applyStimulus(0, 0, 0, 32'h0);

    // Short FS followed by a data word that must be ignored.
    applyStimulus(0, 1, 1, 32'h1A000540);
    checkField("fs_vc", 32'(vc), 32'd1);
    checkField("fs_word_count", 32'(word_count), 32'h5);
    checkField("fs_pulse", 32'(frame_start), 32'd1);
    applyStimulus(0, 1, 0, 32'hDEADBEEF);

    // Long packet, WC = 6, with a 3-cycle in_valid gap inside the body.
    applyStimulus(0, 1, 1, hdrWord(8'h77, 16'd6, 2'd0, 6'h2B));
    applyStimulus(0, 1, 0, 32'h44332211);
    checkField("wc6_be1", 32'(payload_be), 32'hF);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 32'hFFFFFFFF);
    applyStimulus(0, 1, 0, 32'hBBAA6655);
    checkField("wc6_data2", payload_data, 32'h00006655);
    checkField("wc6_crc", 32'(crc), 32'hBBAA);
    applyStimulus(0, 1, 0, 32'h12345678);

    // Long packet, WC = 3: CRC straddles two words.
    applyStimulus(0, 1, 1, hdrWord(8'h01, 16'd3, 2'd2, 6'h2A));
    applyStimulus(0, 1, 0, 32'hCC332211);
    checkField("wc3_be1", 32'(payload_be), 32'h7);
    applyStimulus(0, 1, 0, 32'h000000DD);
    checkField("wc3_crc", 32'(crc), 32'hDDCC);

    // Long packet, WC = 0.
    applyStimulus(0, 1, 1, hdrWord(8'h02, 16'd0, 2'd0, 6'h12));
    applyStimulus(0, 1, 0, 32'hFFFF3412);
    checkField("wc0_crc", 32'(crc), 32'h3412);

    // Abort by a line-start header.
    applyStimulus(0, 1, 1, hdrWord(8'h03, 16'd100, 2'd1, 6'h24));
    applyStimulus(0, 1, 0, 32'h03020100);
    applyStimulus(0, 1, 0, 32'h07060504);
    applyStimulus(0, 1, 1, hdrWord(8'h04, 16'd9, 2'd1, 6'h02));
    checkField("abort_pulse", 32'({pkt_abort, hdr_valid, line_start}), 32'h7);

    // Mid-packet reset, then body words that must be ignored.
    applyStimulus(0, 1, 1, hdrWord(8'h05, 16'd40, 2'd3, 6'h2C));
    applyStimulus(0, 1, 0, 32'hA5A5A5A5);
    applyStimulus(1, 1, 0, 32'h5A5A5A5A);
    applyStimulus(0, 1, 0, 32'h11111111);
    applyStimulus(0, 1, 0, 32'h22222222);

    // Randomized packet traffic.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rdt = 6'($urandom_range(0, 15));
        applyStimulus(0, 1, 1, hdrWord(8'($urandom), 16'($urandom), 2'($urandom), rdt));
      end else begin
        wc = $urandom_range(0, 24);
        rdt = 6'($urandom_range(16, 63));
        applyStimulus(0, 1, 1, hdrWord(8'($urandom), 16'(wc), 2'($urandom), rdt));
        nWords = (wc + 2 + 3) / 4;
        if ($urandom_range(0, 7) == 0) nWords = $urandom_range(0, nWords);
        sent = 0;
        while (sent < nWords) begin
          if ($urandom_range(0, 3) == 0) begin
            applyStimulus(0, 0, 1'($urandom), $urandom);
          end else if ($urandom_range(0, 40) == 0) begin
            applyStimulus(1, 1, 0, $urandom);
            sent = nWords;
          end else begin
            w = $urandom;
            applyStimulus(0, 1, 0, w);
            sent++;
          end
        end
      end
      for (int k = 0; k < $urandom_range(0, 2); k++) applyStimulus(0, 1, 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
